// File: rtl/zeroriscy_bnn_seq_pkg.sv
// zeroriscy_bnn_pkg: shared BNN operator encoding, sequencer states and defaults.
package zeroriscy_bnn_pkg;
    localparam int AW_DEF = 8;
    localparam int NW_DEF = 7;

    typedef enum logic [2:0] {
        INI   = 3'd0,
        ACC   = 3'd1,
        POOL  = 3'd2,
        NORM  = 3'd3,
        ACTIV = 3'd4,
        IP8   = 3'd5,
        SETEN = 3'd6,
        NORM8 = 3'd7
    } bnn_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INI,
        S_FETCH,
        S_ACC,
        S_POOL,
        S_NORM,
        S_ACTIV
    } seq_state_e;

    // Window count minus one: 0 behaves as a single window, anything above 4 saturates.
    function automatic logic [1:0] npos_m1(input logic [2:0] n);
        return (n == 3'd0) ? 2'd0 : (n > 3'd4) ? 2'd3 : 2'(n - 3'd1);
    endfunction
endpackage

// File: rtl/zeroriscy_bnn_seq_if.sv
// zeroriscy_bnn_seq_if: command/result bus between the sequencer and the BNN unit.
interface zeroriscy_bnn_seq_if;
    import zeroriscy_bnn_pkg::*;
    logic        bnn_en_o;
    bnn_op_e     bnn_operator_o;
    logic [6:0]  bnn_param_o;
    logic [31:0] bnn_addr_o;
    logic [31:0] bnn_data_o;
    logic        bnn_ready_i;
    logic [31:0] bnn_result_i;

    modport master (
        output bnn_en_o, bnn_operator_o, bnn_param_o, bnn_addr_o, bnn_data_o,
        input  bnn_ready_i, bnn_result_i
    );
    modport slave (
        input  bnn_en_o, bnn_operator_o, bnn_param_o, bnn_addr_o, bnn_data_o,
        output bnn_ready_i, bnn_result_i
    );
endinterface

// File: rtl/zeroriscy_bnn_seq_cnt.sv
// zeroriscy_bnn_seq_cnt: nested word/window counters and input-buffer address generation.
module zeroriscy_bnn_seq_cnt
    import zeroriscy_bnn_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          fetch,
    input  logic          k_inc,
    input  logic          pos_inc,
    input  logic [NW-1:0] n_in,
    input  logic [1:0]    n_pos_m1,
    input  logic [AW-1:0] in_base,
    output logic [NW-1:0] k,
    output logic          k_last,
    output logic          pos_last,
    output logic          n_in_zero,
    output logic [AW-1:0] in_addr
);
    logic [NW-1:0] n_in_q;
    logic [1:0]    pos, n_pos_q;
    logic [AW-1:0] win, addr_q;

    // win tracks in_base + pos*n_in incrementally, so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_in_q  <= '0;
            n_pos_q <= '0;
            k       <= '0;
            pos     <= '0;
            win     <= '0;
            addr_q  <= '0;
        end else begin
            if (load) begin
                n_in_q  <= n_in;
                n_pos_q <= n_pos_m1;
                k       <= '0;
                pos     <= '0;
                win     <= in_base;
            end else if (pos_inc) begin
                k   <= '0;
                pos <= pos + 2'd1;
                win <= win + AW'(n_in_q);
            end else if (k_inc) begin
                k <= k + NW'(1);
            end
            if (fetch) addr_q <= in_addr;
        end
    end

    // The address is held after FETCH so the buffer output stays put through ACC stalls.
    assign in_addr   = fetch ? win + AW'(k) : addr_q;
    assign n_in_zero = n_in_q == '0;
    assign k_last    = k == n_in_q - NW'(1);
    assign pos_last  = pos == n_pos_q;
endmodule

// File: rtl/zeroriscy_bnn_seq.sv
// zeroriscy_bnn_seq: issues ini / acc* / pool per window / norm / activ for one output word
// and captures the resulting activation bits.
module zeroriscy_bnn_seq
    import zeroriscy_bnn_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int NW = NW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [NW-1:0]         n_in_i,
    input  logic [2:0]            n_pos_i,
    input  logic [15:0]           w_base_i,
    input  logic [15:0]           norm_addr_i,
    input  logic [31:0]           ini_data_i,
    input  logic [AW-1:0]         in_base_i,
    output logic [AW-1:0]         in_addr_o,
    input  logic [31:0]           in_data_i,
    zeroriscy_bnn_seq_if.master   bnn,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           result_o
);
    seq_state_e    state, state_n;
    logic [15:0]   w_base_q, norm_addr_q;
    logic [31:0]   ini_data_q;
    logic [NW-1:0] k;
    logic          load, accept, finish, issue, k_last, pos_last, n_in_zero;

    assign load   = state == S_IDLE && start_i;
    assign accept = bnn.bnn_en_o && bnn.bnn_ready_i;
    assign finish = state == S_ACTIV && accept;

    zeroriscy_bnn_seq_cnt #(.AW(AW), .NW(NW)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .fetch     (state == S_FETCH),
        .k_inc     (state == S_ACC && accept),
        .pos_inc   (state == S_POOL && accept),
        .n_in      (n_in_i),
        .n_pos_m1  (npos_m1(n_pos_i)),
        .in_base   (in_base_i),
        .k         (k),
        .k_last    (k_last),
        .pos_last  (pos_last),
        .n_in_zero (n_in_zero),
        .in_addr   (in_addr_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            w_base_q    <= '0;
            norm_addr_q <= '0;
            ini_data_q  <= '0;
            done_o      <= 1'b0;
            result_o    <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                w_base_q    <= w_base_i;
                norm_addr_q <= norm_addr_i;
                ini_data_q  <= ini_data_i;
            end
            done_o <= finish;
            if (finish) result_o <= bnn.bnn_result_i;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = start_i ? S_INI : S_IDLE;
            S_INI:   if (accept) state_n = n_in_zero ? S_POOL : S_FETCH;
            S_FETCH: state_n = S_ACC;
            S_ACC:   if (accept) state_n = k_last ? S_POOL : S_FETCH;
            S_POOL:  if (accept) state_n = pos_last ? S_NORM : n_in_zero ? S_POOL : S_FETCH;
            S_NORM:  if (accept) state_n = S_ACTIV;
            S_ACTIV: if (accept) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Command fields depend only on state and latched config, so they hold while stalled;
    // rst masks the request combinationally so the BNN unit never sees a half-aborted command.
    assign issue              = state inside {S_INI, S_ACC, S_POOL, S_NORM, S_ACTIV};
    assign bnn.bnn_en_o       = issue && !rst;
    assign bnn.bnn_param_o    = '0;
    assign bnn.bnn_operator_o = (state == S_INI) ? INI :
                                (state inside {S_FETCH, S_ACC}) ? ACC :
                                (state == S_POOL) ? POOL :
                                (state == S_NORM) ? NORM : ACTIV;
    assign bnn.bnn_addr_o     = {16'h0, (state inside {S_FETCH, S_ACC}) ? w_base_q + 16'(k) :
                                        (state == S_NORM) ? norm_addr_q : 16'h0};
    assign bnn.bnn_data_o     = (state inside {S_INI, S_POOL}) ? ini_data_q :
                                (state == S_ACC) ? in_data_i : 32'h0;
    assign busy_o             = state != S_IDLE;
endmodule

// File: tb/tb_zeroriscy_bnn_seq.sv
// tb_zeroriscy_bnn_seq: directed jobs feed an expected-command scoreboard; a negedge monitor
// checks every accepted command, each result/latency at done, and stability during stalls.
module tb_zeroriscy_bnn_seq;
    import zeroriscy_bnn_pkg::*;
    localparam int AW = 8;
    localparam int NW = 7;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1;
    logic [NW-1:0] n_in = '0;
    logic [2:0]    n_pos = '0;
    logic [15:0]   w_base = '0, norm_addr = '0;
    logic [31:0]   ini_data = '0, in_data = '0, result;
    logic [AW-1:0] in_base = '0, in_addr;
    logic          busy, done;
    int            cyc = 0, checks = 0, fails = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] row;
        logic [31:0] data;
        bit          chk_row;
        bit          chk_data;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [31:0] res_q[$];
    int          done_q[$];
    bit          pend = 1'b0;
    logic [31:0] h_op, h_addr, h_data;

    zeroriscy_bnn_seq_if bnn();
    assign bnn.bnn_ready_i  = ready;
    assign bnn.bnn_result_i = {16'hC0DE, cyc[15:0]};

    zeroriscy_bnn_seq #(.AW(AW), .NW(NW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .n_in_i      (n_in),
        .n_pos_i     (n_pos),
        .w_base_i    (w_base),
        .norm_addr_i (norm_addr),
        .ini_data_i  (ini_data),
        .in_base_i   (in_base),
        .in_addr_o   (in_addr),
        .in_data_i   (in_data),
        .bnn         (bnn),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [7:0] a);
        return {8'hA0, a, ~a, a ^ 8'h5A};
    endfunction
    always @(posedge clk) in_data <= mem_val(in_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int push_job(input int ni, input int np, input logic [15:0] wb,
                                    input logic [15:0] nb, input logic [31:0] ini,
                                    input logic [7:0] ib);
        int npe = (np == 0) ? 1 : (np > 4) ? 4 : np;
        cmd_q.push_back(cmd_t'{3'd0, 16'h0, ini, 1'b0, 1'b1});
        for (int p = 0; p < npe; p++) begin
            for (int k = 0; k < ni; k++)
                cmd_q.push_back(cmd_t'{3'd1, 16'(wb + 16'(k)), mem_val(8'(ib + p * ni + k)), 1'b1, 1'b1});
            cmd_q.push_back(cmd_t'{3'd2, 16'h0, ini, 1'b0, 1'b1});
        end
        cmd_q.push_back(cmd_t'{3'd3, nb, 32'h0, 1'b1, 1'b0});
        cmd_q.push_back(cmd_t'{3'd4, 16'h0, 32'h0, 1'b0, 1'b0});
        return 1 + 1 + npe * (2 * ni + 1) + 1 + 1;
    endfunction

    task automatic drive_start(input int ni, input int np, input logic [15:0] wb,
                               input logic [15:0] nb, input logic [31:0] ini, input logic [7:0] ib);
        n_in = NW'(ni); n_pos = 3'(np); w_base = wb; norm_addr = nb; ini_data = ini; in_base = ib;
        start = 1'b1;
    endtask

    task automatic scramble();
        start = 1'b0;
        n_in = 7'h55; n_pos = 3'd3; w_base = 16'hDEAD; norm_addr = 16'hBEEF;
        ini_data = 32'hFFFF_FFFF; in_base = 8'h77;
    endtask

    // stall_at: zero-based index of the acc command held off for three cycles (-1 = none).
    task automatic run_job(input string nm, input int ni, input int np, input logic [15:0] wb,
                           input logic [15:0] nb, input logic [31:0] ini, input logic [7:0] ib,
                           input int stall_at);
        int lat, accs, hold;
        bit stalled, seen;
        lat = push_job(ni, np, wb, nb, ini, ib) + ((stall_at >= 0) ? 3 : 0);
        @(posedge clk); #1;
        drive_start(ni, np, wb, nb, ini, ib);
        done_q.push_back(cyc + lat);
        @(posedge clk); #1;
        scramble();
        accs = 0; hold = 0; stalled = 1'b0; seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            if (hold > 0) begin
                ready = 1'b0; hold--;
            end else if (stall_at >= 0 && !stalled && bnn.bnn_en_o &&
                         bnn.bnn_operator_o == ACC && accs == stall_at) begin
                ready = 1'b0; stalled = 1'b1; hold = 2;
            end else begin
                ready = 1'b1;
            end
            if (bnn.bnn_en_o && bnn.bnn_operator_o == ACC && ready) accs++;
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        ready = 1'b1;
        if (!seen) begin
            checks++; fails++;
            $display("FAIL %s_timeout act=no_done exp=done", nm);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_en"},      32'(bnn.bnn_en_o), 32'h0);
        chk({tag, "_busy"},    32'(busy), 32'h0);
        chk({tag, "_done"},    32'(done), 32'h0);
        chk({tag, "_result"},  result, 32'h0);
        chk({tag, "_in_addr"}, 32'(in_addr), 32'h0);
        chk({tag, "_op"},      32'(bnn.bnn_operator_o), 32'h4);
        chk({tag, "_addr"},    bnn.bnn_addr_o, 32'h0);
        chk({tag, "_data"},    bnn.bnn_data_o, 32'h0);
    endtask

    always @(negedge clk) begin : monitor
        cmd_t c;
        if (!rst) begin
            if (pend) begin
                chk("hold_en",   32'(bnn.bnn_en_o), 32'h1);
                chk("hold_op",   32'(bnn.bnn_operator_o), h_op);
                chk("hold_addr", bnn.bnn_addr_o, h_addr);
                chk("hold_data", bnn.bnn_data_o, h_data);
            end
            pend   = bnn.bnn_en_o && !ready;
            h_op   = 32'(bnn.bnn_operator_o);
            h_addr = bnn.bnn_addr_o;
            h_data = bnn.bnn_data_o;
            if (bnn.bnn_en_o && ready) begin
                if (cmd_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL cmd_extra act=op%0d exp=none", bnn.bnn_operator_o);
                end else begin
                    c = cmd_q.pop_front();
                    chk("cmd_op", 32'(bnn.bnn_operator_o), 32'(c.op));
                    if (c.chk_row) chk("cmd_addr", bnn.bnn_addr_o, {16'h0, c.row});
                    if (c.chk_data) chk("cmd_data", bnn.bnn_data_o, c.data);
                    chk("cmd_param", 32'(bnn.bnn_param_o), 32'h0);
                    if (c.op == 3'd4) res_q.push_back(bnn.bnn_result_i);
                end
            end
            if (done) begin
                if (res_q.size() == 0 || done_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL done_extra act=done exp=idle");
                end else begin
                    chk("result",  result, res_q.pop_front());
                    chk("latency", cyc, done_q.pop_front());
                    chk("busy_at_done", 32'(busy), 32'h0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        run_job("basic", 2, 1, 16'h0010, 16'h0040, 32'h1234_5678, 8'h20, -1);
        run_job("four_win", 3, 4, 16'h0010, 16'h0040, 32'hCAFE_0001, 8'hF0, -1);
        run_job("wrap", 5, 7, 16'hFFFE, 16'h0041, 32'h0BAD_F00D, 8'hF8, -1);
        run_job("stall", 2, 2, 16'h0020, 16'h0042, 32'h5555_AAAA, 8'h40, 1);
        run_job("nin0", 0, 2, 16'h0030, 16'h0043, 32'h7777_0000, 8'h80, -1);
        chk("nin0_in_addr", 32'(in_addr), 32'h43);
        run_job("npos0", 1, 0, 16'h0031, 16'h0044, 32'h0000_1111, 8'h10, -1);

        // Abort mid-run: a second start while busy must be ignored, then reset in POOL.
        void'(push_job(2, 2, 16'h0050, 16'h0045, 32'h2222_3333, 8'h60));
        @(posedge clk); #1;
        drive_start(2, 2, 16'h0050, 16'h0045, 32'h2222_3333, 8'h60);
        @(posedge clk); #1;
        scramble();
        @(posedge clk); #1;
        drive_start(5, 1, 16'h0099, 16'h0099, 32'h9999_9999, 8'h99);
        @(posedge clk); #1;
        scramble();
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (bnn.bnn_en_o && bnn.bnn_operator_o == POOL) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!found) begin
            checks++; fails++;
            $display("FAIL pool_wait_timeout act=no_pool exp=pool");
        end
        rst = 1'b1;
        #1 chk("rst_drop_en", 32'(bnn.bnn_en_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        cmd_q.delete(); res_q.delete(); done_q.delete(); pend = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");

        run_job("after_rst", 2, 1, 16'h0060, 16'h0046, 32'h4444_5555, 8'h30, -1);

        chk("cmd_q_empty",  32'(cmd_q.size()), 32'h0);
        chk("done_q_empty", 32'(done_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
